// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning, 10 Hz tick divider and run/pause/alarm sequencer for the stopwatch datapath
module stopwatch_ctrl #(
  parameter int CLK_HZ          = 50000000,
  parameter int TICK_HZ         = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ALARM_TICKS     = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_ss,
  input  logic btn_clr,
  input  logic btn_mode,
  input  logic count_zero,
  output logic tick,
  output logic running,
  output logic clear,
  output logic countdown,
  output logic lap_hold,
  output logic alarm
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int CW  = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW  = $clog2(ALARM_TICKS + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] AL_MAX  = AW'(ALARM_TICKS);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN_UP, S_RUN_DOWN, S_PAUSE_UP, S_PAUSE_DOWN, S_ALARM
  } state_t;

  logic [2:0] btn, press;
  assign btn = {btn_mode, btn_clr, btn_ss};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic s1_q, s2_q, db_q, dbp_q, press_q;
    logic [CW-1:0] cnt_q;
    logic diff, done;
    assign diff     = s2_q != db_q;
    assign done     = diff && cnt_q == DB_MAX;
    assign press[i] = press_q;
    // Synchronize, require a run of stable differing samples, then emit a one-cycle rising-edge pulse
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        db_q    <= 1'b0;
        dbp_q   <= 1'b0;
        press_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        s1_q    <= btn[i];
        s2_q    <= s1_q;
        cnt_q   <= diff && !done ? cnt_q + 1'b1 : '0;
        db_q    <= done ? s2_q : db_q;
        dbp_q   <= db_q;
        press_q <= db_q & ~dbp_q;
      end
    end
  end

  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [AW-1:0] alm_q, alm_d;
  logic tick_q, tick_d, run_q, clear_q, clear_d, cd_q, cd_d, lap_q, lap_d, alarm_q;
  logic ss, cl, md, adv, wrap;

  assign ss   = press[0];
  assign cl   = press[1] & ~press[0];
  assign md   = press[2] & ~|press[1:0];
  assign adv  = state_q == S_RUN_UP || state_q == S_RUN_DOWN || state_q == S_ALARM;
  assign wrap = div_q == DIV_MAX;

  // Next state, divider phase and control pulses; countdown hitting zero preempts any press
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    lap_d   = lap_q;
    alm_d   = alm_q;
    clear_d = 1'b0;
    tick_d  = wrap && (state_q == S_RUN_UP || (state_q == S_RUN_DOWN && !count_zero));
    div_d   = state_q == S_IDLE ? '0 : adv ? (wrap ? '0 : div_q + 1'b1) : div_q;
    case (state_q)
      S_IDLE: begin
        cd_d    = cd_q ^ md;
        clear_d = cl;
        if (ss && !(cd_q && count_zero)) state_d = cd_q ? S_RUN_DOWN : S_RUN_UP;
      end
      S_RUN_UP: begin
        lap_d = lap_q ^ cl;
        if (ss) state_d = S_PAUSE_UP;
      end
      S_RUN_DOWN: begin
        if (count_zero) begin
          state_d = S_ALARM;
          alm_d   = '0;
        end else begin
          lap_d = lap_q ^ cl;
          if (ss) state_d = S_PAUSE_DOWN;
        end
      end
      S_PAUSE_UP, S_PAUSE_DOWN: begin
        clear_d = cl;
        if (ss) state_d = state_q == S_PAUSE_UP ? S_RUN_UP : S_RUN_DOWN;
        else if (cl) state_d = S_IDLE;
      end
      S_ALARM: begin
        if (wrap) alm_d = alm_q + 1'b1;
        if (|press || (wrap && alm_q + 1'b1 == AL_MAX)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) lap_d = 1'b0;
  end

  // State and registered outputs, all derived from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      alm_q   <= '0;
      tick_q  <= 1'b0;
      run_q   <= 1'b0;
      clear_q <= 1'b0;
      cd_q    <= 1'b0;
      lap_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      alm_q   <= alm_d;
      tick_q  <= tick_d;
      run_q   <= state_d == S_RUN_UP || state_d == S_RUN_DOWN;
      clear_q <= clear_d;
      cd_q    <= cd_d;
      lap_q   <= lap_d;
      alarm_q <= state_d == S_ALARM;
    end
  end

  assign tick      = tick_q;
  assign running   = run_q;
  assign clear     = clear_q;
  assign countdown = cd_q;
  assign lap_hold  = lap_q;
  assign alarm     = alarm_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: randomized scoreboard bench with a behavioural model of the stopwatch sequencer
module tb_stopwatch_ctrl;
  localparam int DIV = 10, DB = 4, AT = 3;
  localparam int IDLE = 0, UP = 1, DN = 2, PU = 3, PD = 4, AL = 5;

  logic clk = 0, reset = 0, cz = 0;
  logic [2:0] b = 0;
  logic tick, running, clear, countdown, lap_hold, alarm;
  int checks = 0, failures = 0;
  logic [5:0] q[$];
  int k, j;

  stopwatch_ctrl #(.CLK_HZ(100), .TICK_HZ(10), .DEBOUNCE_CYCLES(DB), .ALARM_TICKS(AT)) dut (
    .clk(clk), .reset(reset), .btn_ss(b[0]), .btn_clr(b[1]), .btn_mode(b[2]), .count_zero(cz),
    .tick(tick), .running(running), .clear(clear), .countdown(countdown), .lap_hold(lap_hold), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [5:0] a, logic [5:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0t got=%b want=%b (tick,run,clr,cd,lap,alm)", n, $time, a, e);
    end
  endtask

  task automatic chk_i(string n, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", n, a, e);
    end
  endtask

  // Reference model: spec rules evaluated once per clock with the inputs present at that edge
  int m_st = IDLE, rc = 0, ac = 0, nm;
  bit cd = 0, lap = 0, ss, cl, md, adv, wrap, et, ec, nr;
  bit lvl[3], d1[3], d2[3], rose[3], pv[3];
  int run[3];
  bit [2:0] ev;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_st = IDLE; rc = 0; ac = 0; cd = 0; lap = 0;
      for (int i = 0; i < 3; i++) begin
        lvl[i] = 0; run[i] = 0; d1[i] = 0; d2[i] = 0; rose[i] = 0; pv[i] = 0;
      end
      q.delete();
      q.push_back(6'b0);
    end else begin
      ev = {pv[2], pv[1], pv[0]};
      for (int i = 0; i < 3; i++) begin
        nr = 0;
        if (d2[i] != lvl[i]) run[i]++; else run[i] = 0;
        if (run[i] == DB) begin lvl[i] = d2[i]; run[i] = 0; nr = d2[i]; end
        pv[i] = rose[i]; rose[i] = nr;
        d2[i] = d1[i]; d1[i] = b[i];
      end
      ss = ev[0]; cl = ev[1] && !ev[0]; md = ev[2] && !ev[1] && !ev[0];
      adv = m_st == UP || m_st == DN || m_st == AL;
      wrap = adv && (rc % DIV == DIV - 1);
      et = wrap && (m_st == UP || (m_st == DN && !cz));
      ec = 0; nm = m_st;
      case (m_st)
        IDLE: begin
          if (md) cd = !cd;
          if (cl) ec = 1;
          if (ss && !(cd && cz)) nm = cd ? DN : UP;
        end
        UP: begin if (cl) lap = !lap; if (ss) nm = PU; end
        DN: if (cz) begin nm = AL; ac = 0; end else begin if (cl) lap = !lap; if (ss) nm = PD; end
        PU, PD: if (ss) nm = m_st == PU ? UP : DN; else if (cl) begin ec = 1; nm = IDLE; end
        AL: begin if (wrap) ac++; if (ev != 0 || (wrap && ac == AT)) nm = IDLE; end
        default: nm = IDLE;
      endcase
      rc = m_st == IDLE ? 0 : adv ? rc + 1 : rc;
      if (nm == IDLE) lap = 0;
      m_st = nm;
      q.push_back({et, nm == UP || nm == DN, ec, cd, lap, nm == AL});
    end
  end

  // Monitor: compare every presented output cycle with the oldest expectation
  always @(negedge clk)
    if (q.size() > 0) chk("outputs", {tick, running, clear, countdown, lap_hold, alarm}, q.pop_front());

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(bit [2:0] m, int hold = 6);
    b = m; step(hold); b = 0; step(8);
  endtask

  initial begin
    step(3); reset = 1; step(2);
    b[0] = 1; k = 0;
    while (!running && k < 20) begin step(); k++; end
    chk_i("run_latency", k, 8);
    j = 0;
    while (!tick && j < 30) begin step(); j++; end
    chk_i("first_tick", j, 10);
    step(2); b = 0; step(25);
    b[0] = 1; step(); b[0] = 0; step(); b[0] = 1; step(); b[0] = 0; step();
    b[0] = 1; step(10); b[0] = 0; step(10);
    chk_i("bounce_one_press", int'(running), 0);
    push(3'b001); step(7); push(3'b001); step(50); push(3'b001); step(13);
    push(3'b001); push(3'b010); step(5);
    push(3'b100); cz = 1; push(3'b001); cz = 0; push(3'b001); step(15);
    cz = 1; step(40); cz = 0; step(3);
    push(3'b100); push(3'b001); push(3'b010); step(5); push(3'b010); step(12);
    push(3'b011); step(5); push(3'b001); step(7);
    reset = 0; #1;
    chk("async_reset", {tick, running, clear, countdown, lap_hold, alarm}, 6'b0);
    step(3); reset = 1; step(2);
    repeat (3000) begin
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
      if ($urandom_range(0, 39) == 0) cz = ~cz;
      if ($urandom_range(0, 799) == 0) begin reset = 0; step(2); reset = 1; end
      step();
    end
    b = 0; cz = 0; step(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the stopwatch digit datapath. Conditions three raw pushbuttons and runs the up/down/pause/alarm state machine. Produces the datapath's Start/Stop/Clear/Countdown-style controls plus a divided 10 Hz count-enable tick. Sits between the board buttons and the stopwatch counter, with the counter's all-zero flag fed back to stop countdown at 0:00.0.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
TICK_HZ, 10, tick rate in Hz; DIV = CLK_HZ/TICK_HZ, must be an integer >= 2
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (>= 1)
ALARM_TICKS, 30, alarm duration in ticks (3 s at default)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
btn_ss  in  1  raw start/stop button, active-high, asynchronous to clk
btn_clr  in  1  raw clear/lap button, active-high, asynchronous
btn_mode  in  1  raw up/down mode button, active-high, asynchronous
count_zero  in  1  from datapath: all four digits == 0
tick  out  1  one-cycle count-enable pulse at TICK_HZ
running  out  1  high in RUN_UP and RUN_DOWN
clear  out  1  one-cycle pulse that zeroes the datapath digits
countdown  out  1  1 = datapath counts down
lap_hold  out  1  display freeze (lap) while the count continues
alarm  out  1  high in ALARM

Behaviour:
- Reset (reset low, async): state IDLE; all outputs 0; divider, debounce counters, synchronizers and alarm counter cleared.
- Button conditioning, per button:
  - 2-FF synchronizer, then debounce counter.
  - The debounced level updates only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - A press event is a one-cycle pulse on a debounced 0->1 transition. Release generates nothing.
  - Press latency from a clean raw rising edge: exactly DEBOUNCE_CYCLES+3 cycles.
- Same-cycle press priority: ss > clr > mode. Lower-priority events that cycle are discarded.
- Divider:
  - Counter 0..DIV-1, advances in RUN_UP, RUN_DOWN and ALARM; holds in PAUSE_*; forced to 0 in IDLE.
  - tick = 1 for the cycle the counter equals DIV-1; the counter then wraps to 0.
  - The first tick after leaving IDLE comes DIV cycles after the transition.
  - tick is gated: asserted only in RUN_UP/RUN_DOWN (never in ALARM or PAUSE).
- FSM:
  - IDLE:
    - mode press toggles countdown.
    - clr press pulses clear.
    - ss press goes to RUN_UP if countdown=0. If countdown=1, goes to RUN_DOWN if count_zero=0; otherwise stays IDLE.
  - RUN_UP: ss -> PAUSE_UP; clr toggles lap_hold; mode ignored.
  - RUN_DOWN:
    - If count_zero=1, go to ALARM that cycle; tick is suppressed in that cycle, so the datapath never wraps below 0:00.0.
    - Otherwise: ss -> PAUSE_DOWN; clr toggles lap_hold.
  - PAUSE_UP/PAUSE_DOWN:
    - ss -> corresponding RUN state, divider phase preserved.
    - clr -> pulse clear, lap_hold := 0, go to IDLE.
    - mode ignored.
  - ALARM:
    - alarm=1, running=0.
    - Alarm counter increments on each divider wrap.
    - On reaching ALARM_TICKS, or on any press event, go to IDLE; alarm drops the next cycle.
    - countdown unchanged.
- On every entry to IDLE: lap_hold := 0.
- clear is never asserted in a RUN state.
- Reset mid-run: immediate return to the reset values; pending debounce state is discarded.

Test Plan:
(Bench parameters: CLK_HZ=100, TICK_HZ=10 so DIV=10, DEBOUNCE_CYCLES=4, ALARM_TICKS=3.)
1. Reset, then btn_ss high for 20 cycles -> running=1 exactly 7 cycles after the raw edge plus 1 state cycle; first tick 10 cycles after running rises, then every 10 cycles.
2. btn_ss bounce 1,0,1,0 at 1-cycle intervals then steady 1 -> exactly one press event; running toggles once.
3. Run, ss press at divider=6 (pause), hold 50 cycles, ss press again -> no tick while paused; next tick 3 cycles after resuming; clr while paused -> one clear pulse, state IDLE, lap_hold=0.
4. IDLE, mode press -> countdown=1. With count_zero=1, ss press -> stays IDLE. With count_zero=0, ss -> RUN_DOWN. Force count_zero=1 -> alarm=1 the next cycle with no tick that cycle; alarm clears after 3 divider wraps (30 cycles).
5. RUN_UP, clr press -> lap_hold=1 with running still 1 and ticks continuing; second clr -> lap_hold=0.
6. btn_ss and btn_clr debounced in the same cycle while running -> pause only, lap_hold unchanged; reset asserted mid-RUN -> all outputs 0 asynchronously.
